// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - two-requester shared 4-bit multiply/divide scheduler
//
// Purpose: arbitrates two requesters onto one iterative datapath. A granted
// op runs 4 iterations (MSB-first shift/add multiply or restoring divide),
// then a one-cycle DONE presents the result with done/ack, and the FSM returns
// to IDLE. This gives one op per 6 cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                global enable for new grants
//   req0/1, sel0/1    request and op select (0 = mul, 1 = div)
//   a0/1, b0/1        operands: a = multiplicand/divisor, b = multiplier/dividend
//   ack0/1            one-cycle completion pulse to the owner
//   gnt               one-hot datapath owner, 2'b00 when idle
//   busy              high in RUN and DONE
//   done, id, dout    result strobe, owner index, product or {rem, quot}
//
// Configuration macro: MULDIV_SCHED_RR_EN
//   defined   -> round-robin on contested requests
//   undefined -> fixed priority, req0 wins
module muldiv_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req0,
  input  logic       req1,
  input  logic       sel0,
  input  logic       sel1,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       id,
  output logic [7:0] dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e     state_q;
  logic [1:0] cnt_q;
  logic       op_q;
  logic       owner_q;
  logic [3:0] a_q;
  logic [3:0] b_q;     // shifted left each iteration; bit 3 is the current bit
  logic [7:0] acc_q;   // product accumulator, or {remainder, quotient}
  logic [1:0] gnt_q;
  logic [1:0] ack_q;
  logic       busy_q;
  logic       done_q;
  logic       id_q;
  logic [7:0] dout_q;

  logic       winner;
  logic [7:0] acc_d;
  logic [4:0] rem_shift;
  logic [3:0] rem_sub;

`ifdef MULDIV_SCHED_RR_EN
  logic rr_q;  // requester favoured on the next contested grant
  always_comb winner = (req0 && req1) ? rr_q : req1;
`else
  always_comb winner = !req0;
`endif

  // One datapath iteration. For divide, the remainder can never exceed the
  // divisor after a subtract, so its low 4 bits are exact; a zero divisor
  // always subtracts, giving quotient 4'hF and remainder = dividend.
  always_comb begin
    rem_shift = {acc_q[7:4], b_q[3]};
    rem_sub   = rem_shift[3:0] - a_q;
    acc_d     = acc_q;
    if (op_q) begin
      if (rem_shift >= {1'b0, a_q}) acc_d = {rem_sub, acc_q[2:0], 1'b1};
      else                          acc_d = {rem_shift[3:0], acc_q[2:0], 1'b0};
    end else begin
      acc_d = {acc_q[6:0], 1'b0} + {4'b0000, (b_q[3] ? a_q : 4'b0000)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      acc_q   <= 8'd0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= 1'b0;
      dout_q  <= 8'h00;
`ifdef MULDIV_SCHED_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          ack_q  <= 2'b00;
          if (en && (req0 || req1)) begin
            owner_q <= winner;
            op_q    <= winner ? sel1 : sel0;
            a_q     <= winner ? a1 : a0;
            b_q     <= winner ? b1 : b0;
            acc_q   <= 8'd0;
            cnt_q   <= 2'd0;
            gnt_q   <= winner ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef MULDIV_SCHED_RR_EN
            rr_q    <= !winner;
`endif
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          b_q   <= {b_q[2:0], 1'b0};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            dout_q  <= acc_d;
            id_q    <= owner_q;
            ack_q   <= owner_q ? 2'b10 : 2'b01;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ack_q   <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0 = ack_q[0];
  assign ack1 = ack_q[1];
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign id   = id_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - self-checking bench for muldiv_sched
module tb_muldiv_sched;

  logic       clk = 1'b0;
  logic       rst, en, req0, req1, sel0, sel1;
  logic [3:0] a0, a1, b0, b1;
  logic       ack0, ack1, busy, done, id;
  logic [1:0] gnt;
  logic [7:0] dout;

  int   tests = 0;
  int   fails = 0;
  bit   tb_ptr;
  logic [7:0] last_dout;

  muldiv_sched dut (
    .clk(clk), .rst(rst), .en(en),
    .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .gnt(gnt), .busy(busy),
    .done(done), .id(id), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r0, r1, s0, s1;
    logic [3:0] x0, x1, y0, y1;
    logic [7:0] edout;
    logic       eid;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic s, input logic [3:0] a, input logic [3:0] b);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (!s) return 8'(ai * bi);
    if (ai == 0) return {b, 4'hF};
    return {4'(bi % ai), 4'(bi / ai)};
  endfunction

  function automatic logic pick(input logic r0, input logic r1);
`ifdef MULDIV_SCHED_RR_EN
    if (r0 && r1) return tb_ptr;
    return r1;
`else
    return !r0;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic do_op(input logic r0, input logic r1, input logic s0, input logic s1,
                       input logic [3:0] x0, input logic [3:0] x1,
                       input logic [3:0] y0, input logic [3:0] y1,
                       input logic [7:0] edout, input logic eid, input bit hold);
    logic [1:0] egnt;
    egnt = eid ? 2'b10 : 2'b01;
    req0 = r0; req1 = r1; sel0 = s0; sel1 = s1;
    a0 = x0; a1 = x1; b0 = y0; b1 = y1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("gnt_run", 32'(gnt), 32'(egnt));
      chk("busy_run", 32'(busy), 32'd1);
      if (k < 5) begin
        chk("done_early", 32'(done), 32'd0);
        chk("ack_early", 32'({ack1, ack0}), 32'd0);
        chk("dout_hold", 32'(dout), 32'(last_dout));
      end else begin
        chk("done", 32'(done), 32'd1);
        chk("dout", 32'(dout), 32'(edout));
        chk("id", 32'(id), 32'(eid));
        chk("ack", 32'({ack1, ack0}), 32'(egnt));
      end
      if (k == 1) begin
        sel0 = 1'($urandom); sel1 = 1'($urandom);
        a0 = 4'($urandom); a1 = 4'($urandom);
        b0 = 4'($urandom); b1 = 4'($urandom);
        if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (k == 2 && !hold) begin req0 = 1'($urandom); req1 = 1'($urandom); end
      if (k == 4 && !hold) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tb_ptr    = !eid;
    last_dout = edout;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ack_pulse", 32'({ack1, ack0}), 32'd0);
    chk("dout_keep", 32'(dout), 32'(edout));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tb_ptr = 1'b0;
    last_dout = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic r0, r1, s0, s1, w;
    logic [3:0] x0, x1, y0, y1;
    logic [7:0] e;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 4'd0, 4'd11, 4'd0,  8'h8F, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd3, 4'd0,  4'd13, 8'h14, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 4'd9,  4'd0,  8'h9F, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 4'd0, 4'd15, 8'hE1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  4'd0, 4'd15, 4'd0,  8'h0F, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd7, 4'd0,  4'd5,  8'h50, 1'b1};

    rst = 1'b1; en = 1'b1; req0 = 1'b0; req1 = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
    a0 = 4'd0; a1 = 4'd0; b0 = 4'd0; b1 = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    tb_ptr = 1'b0;
    last_dout = 8'h00;

    // en low blocks grants
    en = 1'b0; req0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("en_low_gnt", 32'(gnt), 32'd0);
      chk("en_low_busy", 32'(busy), 32'd0);
    end
    req0 = 1'b0; en = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].r0, vecs[i].r1, vecs[i].s0, vecs[i].s1,
            vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
            vecs[i].edout, vecs[i].eid, 1'b0);

    // Reset during the second iteration discards the op.
    req0 = 1'b1; sel0 = 1'b0; a0 = 4'd5; b0 = 4'd5;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_id", 32'(id), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 32'd0);
      chk("mid_rst_no_ack", 32'({ack1, ack0}), 32'd0);
    end
    tb_ptr = 1'b0;
    last_dout = 8'h00;
    do_op(vecs[0].r0, vecs[0].r1, vecs[0].s0, vecs[0].s1,
          vecs[0].x0, vecs[0].x1, vecs[0].y0, vecs[0].y1,
          vecs[0].edout, vecs[0].eid, 1'b0);

    // Contention with both requests held high.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      s0 = 1'($urandom); s1 = 1'($urandom);
      x0 = 4'($urandom); x1 = 4'($urandom);
      y0 = 4'($urandom); y1 = 4'($urandom);
`ifdef MULDIV_SCHED_RR_EN
      w = (i % 2 == 1);
`else
      w = 1'b0;
`endif
      e = w ? model(s1, x1, y1) : model(s0, x0, y0);
      do_op(1'b1, 1'b1, s0, s1, x0, x1, y0, y1, e, w, 1'b1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Randomized ops against the reference model.
    repeat (40) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      s0 = 1'($urandom); s1 = 1'($urandom);
      x0 = 4'($urandom); x1 = 4'($urandom);
      y0 = 4'($urandom); y1 = 4'($urandom);
      w = pick(r0, r1);
      e = w ? model(s1, x1, y1) : model(s0, x0, y0);
      do_op(r0, r1, s0, s1, x0, x1, y0, y1, e, w, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 SHALL have ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; low blocks new grants; an in-flight op still completes.
- req0, req1  in  1 each  request from requester 0 / 1.
- sel0, sel1  in  1 each  operation select: 0 = multiply, 1 = divide.
- a0, a1  in  4 each  operand d1: multiplicand / divisor.
- b0, b1  in  4 each  operand d2: multiplier / dividend.
- ack0, ack1  out  1 each  one-cycle completion pulse to the owning requester.
- gnt  out  2  one-hot owner of the shared datapath; 2'b00 when idle.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; dout is valid in the same cycle.
- id  out  1  index of the requester whose result is on dout.
- dout  out  8  product, or {remainder[3:0], quotient[3:0]}.

Function
REQ-002 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-003 IDLE: if en=1 and any req is high at an edge, SHALL select a winner, latch its sel/a/b, set gnt, clear the iteration counter, and go to RUN.
REQ-004 Operands SHALL need to be stable only at the capture edge; later changes on a*/b*/sel* SHALL have no effect.
REQ-005 RUN: SHALL perform exactly one shift/add (multiply) or shift/subtract/restore (divide) iteration per clock, for 4 clocks, using a 2-bit counter.
REQ-006 Multiply SHALL process MSB-first and produce the unsigned 8-bit a*b.
REQ-007 Divide SHALL be unsigned restoring division, producing dout[3:0] = b/a and dout[7:4] = b%a.
REQ-008 Divide-by-zero (a=0) SHALL yield quotient 4'hF, remainder = b, and no error flag.
REQ-009 After the 4th iteration the FSM SHALL enter DONE for exactly one cycle. In that cycle: dout updated, done=1, id=winner, ack of the winner=1, the other ack=0.
REQ-010 DONE SHALL always return to IDLE. A new grant SHALL be possible at the edge leaving IDLE, giving one op per 6 cycles. Latency from capture edge to the done cycle SHALL be 5 clocks.
REQ-011 dout and id SHALL hold their last values until the next DONE.
REQ-012 gnt SHALL stay constant from capture through DONE.
REQ-013 Requests arriving during RUN/DONE SHALL be ignored until IDLE; no queuing.
REQ-014 A requester keeping req high after its ack SHALL be treated as a new request.
REQ-015 A req deasserted during RUN SHALL NOT abort the operation; the result and ack are still delivered.
REQ-016 en low in IDLE SHALL keep the FSM in IDLE with gnt=0.

Reset
REQ-017 With rst=1 at an edge the block SHALL set: state=IDLE, gnt=0, busy=0, done=0, ack0=ack1=0, id=0, dout=8'h00, counter=0, and the round-robin pointer favouring requester 0.
REQ-018 Reset mid-RUN or in DONE SHALL discard the operation with no ack or done, and SHALL take priority over all other inputs.

Configuration
REQ-019 Macro MULDIV_SCHED_RR_EN:
- Defined: on simultaneous requests, round-robin. The pointer SHALL switch to the other requester after each grant, and only a contested grant SHALL matter.
- Undefined: fixed priority, req0 always wins, and no pointer register is instantiated.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Multiply: req0, sel0=0, a0=13, b0=11 -> done 5 clocks after capture, dout=8'h8F, id=0, ack0 pulse of 1 cycle.
- Divide: req1, sel1=1, a1=3, b1=13 -> dout=8'h14 (r=1, q=4), id=1, only ack1 pulses.
- Divide by zero: sel=1, a=0, b=9 -> dout=8'h9F.
- Contention: req0 and req1 held high -> with RR_EN, grants alternate 0,1,0,1 every 6 cycles; without RR_EN, requester 0 is granted every time.
- Reset mid-RUN: rst pulse at the 2nd iteration -> no done/ack, dout=8'h00, gnt=0; the next request completes normally.
- Operand change: b0 changed during RUN -> the result still uses the captured value.
